// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order results, with operand
// bypass for dispatch and a full flush when a mispredicted branch reaches head.
module reorder_buffer #(
  parameter int unsigned ROB_WIDTH    = 4,
  parameter int unsigned ROB_SIZE     = 16,
  parameter int unsigned EX_ROB_WIDTH = 5,
  parameter int unsigned NON_DEP      = 16,
  parameter int unsigned EX_REG_WIDTH = 6,
  parameter int unsigned NON_REG      = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    DP2ROB_en,
  input  logic [EX_REG_WIDTH-1:0] DP2ROB_rd,
  input  logic                    DP2ROB_is_branch,
  output logic [ROB_WIDTH-1:0]    ROB2DP_index,
  output logic                    ROB2DP_full,
  input  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qj,
  input  logic [EX_ROB_WIDTH-1:0] DP2ROB_Qk,
  output logic                    ROB2DP_Qj_ready,
  output logic                    ROB2DP_Qk_ready,
  output logic [31:0]             ROB2DP_Vj,
  output logic [31:0]             ROB2DP_Vk,
  input  logic                    CDB_en,
  input  logic [ROB_WIDTH-1:0]    CDB_index,
  input  logic [31:0]             CDB_value,
  input  logic                    CDB_mispredict,
  input  logic [31:0]             CDB_next_pc,
  output logic                    ROB2RF_en,
  output logic [ROB_WIDTH-1:0]    ROB2RF_ROB_index,
  output logic [31:0]             ROB2RF_value,
  output logic [EX_REG_WIDTH-1:0] ROB2RF_rd,
  output logic                    ROB2RF_pre_judge,
  output logic                    ROB2IF_flush,
  output logic [31:0]             ROB2IF_pc
);

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CNT_WIDTH = ROB_WIDTH + 1;

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic                    is_branch;
    logic                    mispredict;
    logic [EX_REG_WIDTH-1:0] rd;
    logic [XLEN-1:0]         value;
    logic [XLEN-1:0]         next_pc;
  } rob_entry_t;

  localparam rob_entry_t EMPTY_ENTRY = '{valid: 1'b0, ready: 1'b0, is_branch: 1'b0,
                                         mispredict: 1'b0, rd: EX_REG_WIDTH'(NON_REG),
                                         value: '0, next_pc: '0};

  rob_entry_t           rob [ROB_SIZE];
  logic [ROB_WIDTH-1:0] head;
  logic [ROB_WIDTH-1:0] tail;
  logic [CNT_WIDTH-1:0] count;

  rob_entry_t head_entry_c;
  logic       full_c;
  logic       commit_c;
  logic       flush_c;
  logic       dispatch_c;

  // Operand lookup: stored result first, then same-cycle writeback bypass.
  function automatic logic [XLEN:0] query_c(input logic [EX_ROB_WIDTH-1:0] q);
    logic [ROB_WIDTH-1:0] idx;
    idx     = q[ROB_WIDTH-1:0];
    query_c = '0;
    if (q[ROB_WIDTH] || q == EX_ROB_WIDTH'(NON_DEP)) begin
      query_c = '0;
    end else if (rob[idx].ready) begin
      query_c = {1'b1, rob[idx].value};
    end else if (CDB_en && CDB_index == idx) begin
      query_c = {1'b1, CDB_value};
    end
  endfunction

  always_comb begin
    head_entry_c = rob[head];
    full_c       = (count == CNT_WIDTH'(ROB_SIZE));
    commit_c     = head_entry_c.valid && head_entry_c.ready;
    flush_c      = commit_c && head_entry_c.mispredict;
    // New work is refused while the pipeline is being redirected.
    dispatch_c   = DP2ROB_en && !full_c && !flush_c && !ROB2IF_flush;
    {ROB2DP_Qj_ready, ROB2DP_Vj} = query_c(DP2ROB_Qj);
    {ROB2DP_Qk_ready, ROB2DP_Vk} = query_c(DP2ROB_Qk);
  end

  assign ROB2DP_full  = full_c;
  assign ROB2DP_index = tail;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(ROB_SIZE); i++) rob[i] <= EMPTY_ENTRY;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      ROB2RF_en        <= 1'b0;
      ROB2RF_ROB_index <= '0;
      ROB2RF_value     <= '0;
      ROB2RF_rd        <= '0;
      ROB2RF_pre_judge <= 1'b1;
      ROB2IF_flush     <= 1'b0;
      ROB2IF_pc        <= '0;
    end else if (rdy_in) begin
      ROB2RF_en        <= 1'b0;
      ROB2RF_pre_judge <= 1'b1;
      ROB2IF_flush     <= 1'b0;
      if (flush_c) begin
        // Mispredicted branch at head: discard everything and redirect fetch.
        for (int i = 0; i < int'(ROB_SIZE); i++) rob[i] <= EMPTY_ENTRY;
        head             <= '0;
        tail             <= '0;
        count            <= '0;
        ROB2RF_pre_judge <= 1'b0;
        ROB2IF_flush     <= 1'b1;
        ROB2IF_pc        <= head_entry_c.next_pc;
      end else begin
        if (CDB_en && rob[CDB_index].valid) begin
          rob[CDB_index].ready      <= 1'b1;
          rob[CDB_index].value      <= CDB_value;
          rob[CDB_index].mispredict <= CDB_mispredict;
          rob[CDB_index].next_pc    <= CDB_next_pc;
        end
        if (commit_c) begin
          rob[head].valid  <= 1'b0;
          rob[head].ready  <= 1'b0;
          ROB2RF_en        <= 1'b1;
          ROB2RF_ROB_index <= head;
          ROB2RF_value     <= head_entry_c.value;
          ROB2RF_rd        <= head_entry_c.rd;
          head             <= head + ROB_WIDTH'(1);
        end
        if (dispatch_c) begin
          rob[tail] <= '{valid: 1'b1, ready: 1'b0, is_branch: DP2ROB_is_branch,
                         mispredict: 1'b0, rd: DP2ROB_rd, value: '0, next_pc: '0};
          tail      <= tail + ROB_WIDTH'(1);
        end
        count <= count + CNT_WIDTH'(dispatch_c) - CNT_WIDTH'(commit_c);
      end
    end
  end

endmodule
